multicycle_main_control: RTL
============================

Name: multicycle_main_control

Overview:
- Multi-cycle MIPS main control FSM. It decodes the instruction-register opcode and sequences the datapath through fetch, decode, execute, memory and writeback.
- It is the producer of the 2-bit ALU-op code consumed by the ALU control decoder:
  - 00: add
  - 01: subtract, for branch compare
  - 10: use funct field
- Moore-style outputs are decoded from the state register. Memory handshake is via mem_ready.

Parameters:
- OP_RTYPE, 6'h00, R-format opcode
- OP_LW, 6'h23, load word
- OP_SW, 6'h2B, store word
- OP_BEQ, 6'h04, branch equal
- OP_J, 6'h02, jump
- OP_ADDI, 6'h08, add immediate

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; stable outside FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC load = pc_write | (pc_write_cond & zero)
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  destination register: 0 rt, 1 rd
- mem_to_reg  out  1  writeback data: 0 ALUOut, 1 MDR
- reg_write  out  1  register-file write
- alu_src_a  out  1  ALU A operand: 0 PC, 1 A
- alu_src_b  out  2  ALU B operand: 00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2
- alu_op  out  2  code to the ALU control decoder
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- state  out  4  current state, for debug

Behaviour:
- State register is 4 bits. Every output not listed for a state is 0.
- S0 FETCH:
  - Outputs: mem_read=1, alu_src_b=01, alu_op=00; ir_write=mem_ready; pc_write=mem_ready.
  - Next: DECODE if mem_ready, else stay in FETCH.
- S1 DECODE:
  - Outputs: alu_src_b=11, alu_op=00 (branch target precompute).
  - Next: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, ADDI->ADDIEX, any other opcode->FETCH (see optional feature).
- S2 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: LW->MEMRD, otherwise MEMWR.
- S3 MEMRD: mem_read=1, iord=1. Stay until mem_ready, then MEMWB.
- S4 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next: FETCH.
- S5 MEMWR: mem_write=1, iord=1. Stay until mem_ready, then FETCH; instr_done=mem_ready.
- S6 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- S7 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next: FETCH.
- S8 BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1, instr_done=1.
  - pc_en equals zero. Next: FETCH.
- S9 JUMP: pc_source=10, pc_write=1, instr_done=1. Next: FETCH.
- S10 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
- S11 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next: FETCH.
- States 12-15 (when unused) -> FETCH on the next edge, all outputs 0.
- Latency with mem_ready tied to 1:
  - LW 5 cycles
  - SW, R-type, ADDI 4 cycles
  - BEQ, J 3 cycles
- Each wait cycle (mem_ready=0) in FETCH, MEMRD or MEMWR adds exactly one cycle. No write-enable pulses during a wait, except mem_read/mem_write held high.
- opcode is sampled only in DECODE and MEMADR.
- Reset:
  - While reset=1, every output is forced to 0 combinationally (including state-derived enables). Next state is FETCH.
  - Reset in any state, including mid-wait, aborts the instruction with no register, memory or PC write.
  - First cycle after reset deasserts is FETCH.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - Adds an extra output port exc (1 bit, reset 0) and state S12 TRAP.
  - DECODE with an undefined opcode -> TRAP.
  - TRAP outputs: pc_source=11, pc_write=1, exc=1, instr_done=1. Next: FETCH.
- Not defined:
  - No exc port and no TRAP state.
  - Undefined opcode in DECODE -> FETCH with no side effects and instr_done=0 (treated as NOP).

Test Plan:
- Reset 2 cycles, mem_ready=1, opcode=6'h23 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_done pulses once.
- opcode=6'h00, mem_ready=1 -> alu_op=10 in state 6; reg_write=1 with reg_dst=1 in state 7; 4 cycles total.
- opcode=6'h04:
  - zero=1 in state 8 -> pc_en=1, pc_source=01, alu_op=01.
  - Repeat with zero=0 -> pc_en=0.
- opcode=6'h2B with mem_ready held 0 for 3 cycles in MEMWR -> mem_write=1 for 4 cycles; instr_done only in the final cycle; next state FETCH.
- Assert reset in MEMRD while mem_ready=0 -> all outputs 0 that cycle; state=0 next; no reg_write ever asserted.
- opcode=6'h3F:
  - With ILLEGAL_OP_TRAP_EN -> state 12 with exc=1, pc_source=11, pc_en=1, then state 0.
  - Without it -> state 1 to 0 with no enables.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional macro ILLEGAL_OP_TRAP_EN adds the exc output and a TRAP state for undefined opcodes.
module multicycle_main_control #(
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_J     = 6'h02,
   parameter logic [5:0] OP_ADDI  = 6'h08
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic [1:0] pc_source,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       instr_done,
`ifdef ILLEGAL_OP_TRAP_EN
   output logic       exc,
`endif
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
      , S_TRAP = 4'd12
`endif
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   pc_write_s;
   logic   pc_write_cond_s;

   // Next-state selection; opcode only matters in DECODE and MEMADR.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
`ifdef ILLEGAL_OP_TRAP_EN
               default:      state_d = S_TRAP;
`else
               default:      state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // State register with synchronous reset to FETCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Moore decode of the state register; reset blanks every output in the same cycle.
   always_comb begin
      pc_write_s      = 1'b0;
      pc_write_cond_s = 1'b0;
      pc_source       = 2'b00;
      iord            = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      ir_write        = 1'b0;
      reg_dst         = 1'b0;
      mem_to_reg      = 1'b0;
      reg_write       = 1'b0;
      alu_src_a       = 1'b0;
      alu_src_b       = 2'b00;
      alu_op          = 2'b00;
      instr_done      = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      exc             = 1'b0;
`endif
      state           = 4'd0;
      if (reset) begin
         state = 4'd0;
      end else begin
         state = state_q;
         case (state_q)
            S_FETCH: begin
               mem_read   = 1'b1;
               alu_src_b  = 2'b01;
               ir_write   = mem_ready;
               pc_write_s = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               instr_done = 1'b1;
            end
            S_MEMWR: begin
               mem_write  = 1'b1;
               iord       = 1'b1;
               instr_done = mem_ready;
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            S_ALUWB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a       = 1'b1;
               alu_op          = 2'b01;
               pc_source       = 2'b01;
               pc_write_cond_s = 1'b1;
               instr_done      = 1'b1;
            end
            S_JUMP: begin
               pc_source  = 2'b10;
               pc_write_s = 1'b1;
               instr_done = 1'b1;
            end
            S_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: begin
               pc_source  = 2'b11;
               pc_write_s = 1'b1;
               exc        = 1'b1;
               instr_done = 1'b1;
            end
`endif
            default: state = state_q;
         endcase
      end
      pc_en = pc_write_s | (pc_write_cond_s & zero);
   end

endmodule
